// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide sequencer (radix-2 shift-add multiply, restoring divide).
// Define MULDIV_DIV_EN to build the divider; without it divide ops complete at once with illegalE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] src1E,
  input  logic [WIDTH-1:0] src2E,
  input  logic             flush,
  output logic             stallE,
  output logic             doneE,
  output logic [WIDTH-1:0] resultE,
  output logic             busy,
  output logic             illegalE
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic [WIDTH-1:0] hi, lo, mcand;
  logic             neg_main;
  logic             illegal;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  // Accept-cycle decode: operand signedness, magnitudes, special outcomes
  logic             accept;
  logic             s1_signed, s2_signed, sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             special, illegal_op;
  logic [WIDTH-1:0] special_val;

  assign accept = (state == IDLE) && startE && !flush;

  always_comb begin
    s1_signed = 1'b0;
    s2_signed = 1'b0;
    case (opE)
      3'b001, 3'b100, 3'b110: begin s1_signed = 1'b1; s2_signed = 1'b1; end
      3'b010:                 s1_signed = 1'b1;
      default:                ;
    endcase
  end

  assign sa    = s1_signed & src1E[WIDTH-1];
  assign sb    = s2_signed & src2E[WIDTH-1];
  assign a_mag = neg_if(src1E, sa);
  assign b_mag = neg_if(src2E, sb);

`ifdef MULDIV_DIV_EN
  logic neg_rem;

  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (opE[2]) begin
      if (src2E == '0) begin
        special     = 1'b1;
        special_val = opE[1] ? src1E : '1;
      end else if (!opE[0] && src1E == {1'b1, {(WIDTH-1){1'b0}}} && src2E == '1) begin
        special     = 1'b1;
        special_val = opE[1] ? '0 : src1E;
      end
    end
  end
  assign illegal_op = 1'b0;
`else
  assign special     = opE[2];
  assign special_val = '0;
  assign illegal_op  = opE[2];
`endif

  // One iteration step; multiply shifts right through {hi,lo}, divide shifts left
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   hi_step, lo_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] div_shift, div_trial;
`endif

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    hi_step = mul_sum[WIDTH:1];
    lo_step = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {hi, lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, mcand};
    if (op[2]) begin
      if (!div_trial[WIDTH]) begin
        hi_step = div_trial[WIDTH-1:0];
        lo_step = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = div_shift[WIDTH-1:0];
        lo_step = {lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
    prod = neg_if_wide({hi_step, lo_step}, neg_main);
    fin  = (op == 3'b000) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
    if (op[2]) fin = op[1] ? neg_if(hi_step, neg_rem) : neg_if(lo_step, neg_main);
`endif
  end

  // Sequencer state
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (startE) state_next = special ? DONE : RUN;
        RUN:     if (cnt == '0) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Control registers and the architecturally visible result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      resultE <= '0;
      illegal <= 1'b0;
    end else begin
      illegal <= accept && illegal_op;
      if (accept) begin
        cnt <= CNT_W'(WIDTH-1);
        if (special) resultE <= special_val;
      end else if (state == RUN && !flush) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) resultE <= fin;
      end
    end
  end

  // Datapath registers, loaded only at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      op       <= opE;
      hi       <= '0;
      lo       <= a_mag;
      mcand    <= b_mag;
      neg_main <= sa ^ sb;
`ifdef MULDIV_DIV_EN
      neg_rem  <= sa;
`endif
    end else if (state == RUN) begin
      hi <= hi_step;
      lo <= lo_step;
    end
  end

  assign stallE   = accept || (state == RUN);
  assign busy     = (state == RUN);
  assign doneE    = (state == DONE);
  assign illegalE = illegal;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle timeline checks of all outputs.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, startE, flush;
  logic [2:0]    opE;
  logic [W-1:0]  src1E, src2E, resultE;
  logic          stallE, doneE, busy, illegalE;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE), .src1E(src1E), .src2E(src2E),
    .flush(flush), .stallE(stallE), .doneE(doneE), .resultE(resultE), .busy(busy),
    .illegalE(illegalE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Reference arithmetic from the RV32M definitions
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = 64'(ua * ub); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
`ifdef MULDIV_DIV_EN
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
    return op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
`else
    return op[2] && (a == a);
`endif
  endfunction

  function automatic bit ref_illegal(input logic [2:0] op);
`ifdef MULDIV_DIV_EN
    return 1'b0 && op[0];
`else
    return op[2];
`endif
  endfunction

  // Model timeline of the op in flight
  bit           chk_en = 0, pend = 0, done_real = 0, exp_ill = 0;
  int           t_acc = 0, t_done = 0, rst_res_at = -1;
  logic [31:0]  exp_res = 0, held = 0, seen_res = 0;
  logic         seen_ill = 0;
  int           seen_cyc = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit e_done, e_stall, e_busy;
      if (cyc == rst_res_at) held = 32'd0;
      e_done  = pend && done_real && cyc == t_done;
      e_stall = pend && cyc >= t_acc && cyc < t_done;
      e_busy  = pend && cyc > t_acc && cyc < t_done;
      if (e_done) held = exp_res;
      check("stallE", 32'(stallE), 32'(e_stall));
      check("busy", 32'(busy), 32'(e_busy));
      check("doneE", 32'(doneE), 32'(e_done));
      check("illegalE", 32'(illegalE), 32'(e_done && exp_ill));
      check("resultE", resultE, held);
      if (doneE) begin
        seen_res = resultE;
        seen_ill = illegalE;
        seen_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    startE = 1'b1; opE = op; src1E = a; src2E = b;
    t_acc     = cyc;
    t_done    = cyc + (ref_fast(op, a, b) ? 1 : W + 1);
    exp_res   = ref_result(op, a, b);
    exp_ill   = ref_illegal(op);
    done_real = 1;
    pend      = 1;
  endtask

  // Runs one op with startE held through DONE and operands scrambled after accept
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit keep);
    issue(op, a, b);
    while (cyc <= t_done) begin
      step();
      src1E = $urandom;
      src2E = $urandom;
    end
    if (!keep) startE = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t0;
    reset = 1'b1; startE = 1'b0; flush = 1'b0; opE = 3'd0; src1E = '0; src2E = '0;
    repeat (3) step();
    reset = 1'b0;
    chk_en = 1;
    step();

    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 0);
    check("mul_7", seen_res, 32'hFFFFFFEB);
    check("mul_latency", 32'(seen_cyc - t_acc), 32'd33);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("mulhu", seen_res, 32'hFFFFFFFE);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("mulh", seen_res, 32'h00000000);
    step();

`ifdef MULDIV_DIV_EN
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 0);
    check("div_neg", seen_res, 32'hFFFFFFFD);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 0);
    check("rem_neg", seen_res, 32'hFFFFFFFF);
    run_op(3'd5, 32'd100, 32'd7, 0);
    check("divu", seen_res, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 0);
    check("remu", seen_res, 32'd2);
    run_op(3'd4, 32'h55, 32'd0, 0);
    check("div_by0", seen_res, 32'hFFFFFFFF);
    check("div_by0_lat", 32'(seen_cyc - t_acc), 32'd1);
    run_op(3'd6, 32'h1234, 32'd0, 0);
    check("rem_by0", seen_res, 32'h1234);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
    check("div_ovf", seen_res, 32'h80000000);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
    check("rem_ovf", seen_res, 32'd0);
`else
    run_op(3'd5, 32'd9, 32'd3, 0);
    check("illegal_flag", 32'(seen_ill), 32'd1);
    check("illegal_res", seen_res, 32'd0);
    check("illegal_lat", 32'(seen_cyc - t_acc), 32'd1);
`endif
    step();

    // Back-to-back multiplies
    t0 = cyc;
    run_op(3'd0, 32'd3, 32'd4, 1);
    check("b2b_first", seen_res, 32'd12);
    check("b2b_first_lat", 32'(seen_cyc - t0), 32'd33);
    run_op(3'd0, 32'd5, 32'd6, 0);
    check("b2b_second", seen_res, 32'd30);
    check("b2b_second_lat", 32'(seen_cyc - t0), 32'd67);
    step();

    // Flush mid-multiply: no done, result keeps 30
    issue(3'd0, 32'd9, 32'd9);
    repeat (10) step();
    flush = 1'b1; startE = 1'b0;
    t_done = cyc + 1; done_real = 0;
    step();
    flush = 1'b0;
    repeat (3) step();
    check("flush_keep", resultE, 32'd30);

    // Flush beats start in the same cycle
    startE = 1'b1; flush = 1'b1; opE = 3'd0; src1E = 32'd2; src2E = 32'd2;
    step();
    startE = 1'b0; flush = 1'b0;
    step();
    check("flush_wins", 32'(busy), 32'd0);

    // Reset mid-multiply
    issue(3'd0, 32'd11, 32'd13);
    repeat (5) step();
    reset = 1'b1; startE = 1'b0;
    t_done = cyc + 1; done_real = 0; rst_res_at = cyc + 1;
    step();
    reset = 1'b0;
    check("rst_result", resultE, 32'd0);
    step();

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [2:0] rop;
      bit k;
      rop = 3'($urandom_range(0, 7));
      k = ($urandom_range(0, 2) == 0);
      run_op(rop, pick(), pick(), k);
      if (!k && $urandom_range(0, 1) == 1) step();
    end
    startE = 1'b0;
    repeat (4) step();
    chk_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
